fbank_lut_sequencer: RTL
========================

// Module: fbank_lut_sequencer
// PURPOSE
//  Owns the single-port FBANK_LUT1 weight RAM (10b addr, 17b data, 1-cycle read, no out reg).
//  Per spectral frame, walks LUT entries 0..NUM_BINS-1 and streams decoded
//  (bin, filter id, weight) triples to the Mel-filterbank MAC over valid/ready.
//  Arbitrates RAM access between the host config-write port and the frame sequencer.
// PARAMETERS
//  ADDR_WIDTH  10    LUT address width
//  DATA_WIDTH  17    LUT word width; word = {filt_id[5:0], weight[10:0]}
//  NUM_BINS    257   entries per frame (512-pt FFT); legal range 1..2**ADDR_WIDTH
// PORTS
//  clk          in   1    system clock
//  rst          in   1    synchronous, active-high reset
//  start        in   1    1-cycle pulse: begin a frame pass (ignored unless idle)
//  busy         out  1    high from the cycle after an accepted start until the cycle done pulses
//  done         out  1    1-cycle pulse when the last triple has been accepted
//  cfg_wr_en    in   1    host LUT write request
//  cfg_addr     in   10   host write address
//  cfg_data     in   17   host write data
//  cfg_ready    out  1    host write accepted this cycle (= ~busy & ~start)
//  lut_addr     out  10   to LUT addr
//  lut_wr_data  out  17   to LUT wr_data
//  lut_wr_en    out  1    to LUT wr_en
//  lut_rd_data  in   17   from LUT rd_data, valid 1 cycle after lut_addr
//  out_valid    out  1    triple valid
//  out_ready    in   1    MAC accepts triple
//  out_bin      out  10   spectral bin index (= LUT address read)
//  out_filt     out  6    Mel filter id (lower filter; MAC applies 2048-w to out_filt+1)
//  out_weight   out  11   unsigned Q0.11 weight
// BEHAVIOUR
//  Reset: busy=0, done=0, out_valid=0, lut_wr_en=0, lut_addr=0, out_* data=0,
//   FIFO empty, FSM=IDLE. Reset mid-frame aborts with no done pulse.
//  FSM: IDLE -start-> RUN (rd_ptr=0) -all NUM_BINS reads issued-> DRAIN
//   -FIFO empty & no read in flight-> IDLE, pulsing done on that exit cycle.
//  Arbitration: host write is granted only in IDLE with start low; a start on the same
//   cycle as cfg_wr_en wins, and the write stalls (cfg_ready=0).
//   Granted write drives lut_addr=cfg_addr, lut_wr_data=cfg_data, lut_wr_en=1 that cycle.
//   lut_wr_en is never 1 outside IDLE.
//  Reads: in RUN a read issues (lut_addr=rd_ptr, rd_ptr++) only if
//   fifo_count + inflight < 2 (credit rule); inflight is a 1-bit reg tagging the
//   returned word with its bin. Returned word is pushed into a 2-entry skid FIFO next cycle.
//  Skip: words with filt_id==6'h3F (SKIP_ID) are dropped at push, not emitted, but still
//   count toward NUM_BINS.
//  Output: out_* driven from the FIFO head; registered, no combinational ready->valid path.
//   Pop on out_valid&out_ready. out_* hold stable while out_valid&~out_ready.
//  Latency: start at cycle T -> lut_addr=0 at T+1 -> first out_valid at T+3 (non-skip).
//   Sustained 1 triple/cycle while out_ready=1.
//  Boundaries: start while busy ignored; NUM_BINS=1 legal; rd_ptr stops at NUM_BINS-1
//   (no wrap). A frame of all-skip entries still pulses done. done is never asserted with
//   out_valid after it in the same frame.
// STRUCTURE
//  fbank_pkg: FILT_W=6, WEIGHT_W=11, SKIP_ID=6'h3F, fbank_word_t {filt,weight},
//   fbank_triple_t {bin,filt,weight}, FSM state enum {IDLE,RUN,DRAIN}.
//  Sub-module fbank_skid_fifo: 2-entry registered FIFO of fbank_triple_t, push/pop/count.
//  Top: FSM, rd_ptr, inflight tag, arbitration mux onto lut_* ports.
// TESTING  (bench instantiates FBANK_LUT1 behavioural model, NUM_BINS=8)
//  1 Idle host writes addr0..7 = {filt=k,w=100*k}; then start, out_ready=1 -> 8 triples,
//   bins 0..7 in order, first out_valid at T+3, done 1 cycle after the 8th handshake.
//  2 out_ready toggles 1,0,0,1 randomly -> no loss or duplicate; out_* stable while stalled;
//   lut_addr never advances past 2 unaccepted words.
//  3 Entries 2 and 5 hold filt=6'h3F -> exactly 6 triples (bins 0,1,3,4,6,7); done still pulses.
//  4 cfg_wr_en held during RUN -> cfg_ready=0, lut_wr_en=0 until IDLE; write lands the cycle
//   after done; start+cfg_wr_en same cycle in IDLE -> start wins.
//  5 rst asserted at 3rd output -> next cycle out_valid=0, busy=0, done=0; fresh start replays from bin 0.
//  6 start pulsed again while busy -> ignored; exactly one done per frame.

Source files
------------

// File: rtl/fbank_pkg.sv
// Shared types for the Mel filterbank LUT sequencer.
//   BIN_W / FILT_W / WEIGHT_W : field widths of a decoded LUT entry
//   SKIP_ID                   : filter id marking a bin that feeds no filter
//   fbank_word_t              : raw LUT word {filt, weight}
//   fbank_triple_t            : streamed entry {bin, filt, weight}
//   fbank_state_t             : sequencer FSM states
package fbank_pkg;

    localparam int BIN_W    = 10;
    localparam int FILT_W   = 6;
    localparam int WEIGHT_W = 11;

    localparam logic [FILT_W-1:0] SKIP_ID = 6'h3F;

    typedef struct packed {
        logic [FILT_W-1:0]   filt;
        logic [WEIGHT_W-1:0] weight;
    } fbank_word_t;

    typedef struct packed {
        logic [BIN_W-1:0]    bin;
        logic [FILT_W-1:0]   filt;
        logic [WEIGHT_W-1:0] weight;
    } fbank_triple_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fbank_state_t;

    function automatic logic is_skip(input fbank_word_t w);
        return w.filt == SKIP_ID;
    endfunction

endpackage

// File: rtl/fbank_skid_fifo.sv
// Two-entry registered FIFO of decoded triples sitting between the LUT read
// return and the MAC handshake. The head is read straight out of storage
// registers, so the output side has no combinational path from pop.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data this cycle (caller guarantees room)
//   push_data  : triple to store
//   pop        : drop the head this cycle (caller guarantees not empty)
//   head       : oldest stored triple
//   count      : number of stored triples, 0..2
module fbank_skid_fifo
    import fbank_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fbank_triple_t push_data,
    input  logic          pop,
    output fbank_triple_t head,
    output logic [1:0]    count
);

    fbank_triple_t mem [2];
    logic          wr_idx;
    logic          rd_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_idx];

endmodule

// File: rtl/fbank_lut_sequencer.sv
// Frame sequencer for the FBANK_LUT1 weight RAM. Owns the RAM port, lets the
// host write entries while idle, and on start walks entries 0..NUM_BINS-1,
// streaming decoded (bin, filter, weight) triples to the Mel MAC.
//   clk, rst                         : clock, synchronous active-high reset
//   start / busy / done              : frame pass control and status
//   cfg_wr_en, cfg_addr, cfg_data    : host write request; cfg_ready = accepted
//   lut_addr, lut_wr_data, lut_wr_en : RAM port (1-cycle read into lut_rd_data)
//   out_valid / out_ready            : triple handshake to the MAC
//   out_bin, out_filt, out_weight    : triple fields (weight is Q0.11)
//
// state | meaning
// IDLE  | host owns the RAM port; waiting for start
// RUN   | issuing reads for bins 0..NUM_BINS-1 under the credit rule
// DRAIN | all reads issued; waiting for last word to return and be accepted
module fbank_lut_sequencer
    import fbank_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 17,
    parameter int NUM_BINS   = 257
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic                  cfg_ready,
    output logic [ADDR_WIDTH-1:0] lut_addr,
    output logic [DATA_WIDTH-1:0] lut_wr_data,
    output logic                  lut_wr_en,
    input  logic [DATA_WIDTH-1:0] lut_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_bin,
    output logic [FILT_W-1:0]     out_filt,
    output logic [WEIGHT_W-1:0]   out_weight
);

    localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(NUM_BINS - 1);

    fbank_state_t          state, state_nxt;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_bin;
    logic                  inflight;
    logic                  issue;
    logic                  grant_wr;
    logic                  credit_ok;
    logic [2:0]            occ_after_pop;

    fbank_word_t           rd_word;
    fbank_triple_t         push_data;
    fbank_triple_t         fifo_head;
    logic [1:0]            fifo_count;
    logic                  push;
    logic                  pop;

    // Credit counts the head leaving this cycle so that a full pipe with
    // out_ready high still issues one read per cycle; stored plus in-flight
    // words never exceed the two FIFO slots.
    assign pop           = out_valid & out_ready;
    assign occ_after_pop = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign credit_ok     = occ_after_pop < 3'd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (rd_ptr == LAST_BIN) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_count == 2'd0 && !inflight) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rd_ptr parks on the last bin rather than wrapping; rd_bin tags the word
    // returning next cycle with the address it was read from.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            rd_bin   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                rd_bin <= rd_ptr;
            end
            if (state == IDLE && start) begin
                rd_ptr <= '0;
            end else if (issue && rd_ptr != LAST_BIN) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    assign busy      = (state != IDLE);
    assign cfg_ready = ~busy & ~start;
    assign grant_wr  = cfg_wr_en & cfg_ready;

    always_comb begin
        lut_addr    = '0;
        lut_wr_data = '0;
        lut_wr_en   = 1'b0;
        if (grant_wr) begin
            lut_addr    = cfg_addr;
            lut_wr_data = cfg_data;
            lut_wr_en   = 1'b1;
        end else if (state == RUN) begin
            lut_addr = rd_ptr;
        end
    end

    assign rd_word          = fbank_word_t'(lut_rd_data);
    assign push             = inflight & ~is_skip(rd_word);
    assign push_data.bin    = rd_bin;
    assign push_data.filt   = rd_word.filt;
    assign push_data.weight = rd_word.weight;

    fbank_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign out_valid  = (fifo_count != 2'd0);
    assign out_bin    = fifo_head.bin;
    assign out_filt   = fifo_head.filt;
    assign out_weight = fifo_head.weight;

endmodule
